// File: rtl/fb_access_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_access_scheduler                                                      |
// | Shares one single-port frame-buffer RAM between VGA reads and buffered   |
// | camera writes; reads own the active area, writes drain during blanking.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+

module fb_access_scheduler #(
  parameter int AW         = 19,
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = 8
) (
  input  logic                          CLK25,
  input  logic                          reset,
  input  logic                          rez_160x120,
  input  logic                          rez_320x240,
  input  logic                          activeArea,
  input  logic                          Vsync,
  input  logic                          wr_req,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic [DW-1:0]                 pix_data,
  output logic                          pix_valid,
  output logic                          wr_drop,
  output logic [CW-1:0]                 drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [AW-1:0] SIZE_160 = AW'(19200);
  localparam logic [AW-1:0] SIZE_320 = AW'(76800);
  localparam logic [AW-1:0] SIZE_640 = AW'(307200);

  function automatic logic [AW-1:0] rez_size(input logic r160, input logic r320);
    if (r160)      rez_size = SIZE_160;
    else if (r320) rez_size = SIZE_320;
    else           rez_size = SIZE_640;
  endfunction

  logic          vsync_q, vsync_d;
  logic [AW-1:0] frame_size_q, frame_size_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          act_d1_q, act_d1_d;
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic          wr_drop_q, wr_drop_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [AW+DW-1:0] fifo_mem [FIFO_DEPTH];

  logic             fifo_empty;
  logic             fifo_full;
  logic             frame_start;
  logic             pop;
  logic             push;
  logic             drop;
  logic [AW+DW-1:0] head;

  always_comb begin
    fifo_empty  = (level_q == '0);
    fifo_full   = (level_q == LW'(FIFO_DEPTH));
    frame_start = vsync_q & ~Vsync;
    pop         = ~activeArea & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push        = wr_req & (~fifo_full | pop);
    drop        = wr_req & ~push;
    head        = fifo_mem[rd_ptr_q];
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (activeArea) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr_q;
      end else if (pop) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head[AW+DW-1:DW];
        mem_wdata = head[DW-1:0];
      end
    end
  end

  always_comb begin
    vsync_d      = Vsync;
    frame_size_d = frame_size_q;
    rd_addr_d    = rd_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q + LW'(push) - LW'(pop);
    act_d1_d     = activeArea;
    pix_valid_d  = act_d1_q;
    pix_data_d   = act_d1_q ? mem_rdata : pix_data_q;
    wr_drop_d    = drop;
    drop_cnt_d   = drop_cnt_q;

    // Frame start overrides the post-read increment of the same cycle.
    if (frame_start) begin
      rd_addr_d    = '0;
      frame_size_d = rez_size(rez_160x120, rez_320x240);
    end else if (activeArea) begin
      rd_addr_d = (rd_addr_q == frame_size_q - AW'(1)) ? '0 : rd_addr_q + AW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK25) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      frame_size_q <= rez_size(rez_160x120, rez_320x240);
      rd_addr_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      act_d1_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      wr_drop_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      vsync_q      <= vsync_d;
      frame_size_q <= frame_size_d;
      rd_addr_q    <= rd_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      act_d1_q     <= act_d1_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      wr_drop_q    <= wr_drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge CLK25) begin
    if (push) fifo_mem[wr_ptr_q] <= {wr_addr, wr_data};
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign wr_drop    = wr_drop_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_access_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_access_scheduler                                                   |
// | Directed bench: vector table for slot/pipeline behaviour plus sequences. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+

module tb_fb_access_scheduler;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int FD = 16;
  localparam int CW = 8;

  logic          CLK25 = 1'b0;
  logic          reset;
  logic          rez_160x120, rez_320x240;
  logic          activeArea, Vsync;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid, wr_drop;
  logic [CW-1:0] drop_cnt;
  logic [4:0]    fifo_level;

  always #5 CLK25 = ~CLK25;

  fb_access_scheduler #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD), .CW(CW)) dut (
    .CLK25(CLK25), .reset(reset), .rez_160x120(rez_160x120), .rez_320x240(rez_320x240),
    .activeArea(activeArea), .Vsync(Vsync), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data),
    .pix_valid(pix_valid), .wr_drop(wr_drop), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge CLK25);
    #1;
  endtask

  typedef struct {
    logic          act;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [4:0]    lvl;
    logic          pv;
    logic [DW-1:0] pix;
  } vec_t;

  function automatic vec_t mk(input logic act, input logic wr, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input logic en, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [4:0] lvl,
                              input logic pv, input logic [DW-1:0] pix);
    vec_t v;
    v.act = act; v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.lvl = lvl; v.pv = pv; v.pix = pix;
    return v;
  endfunction

  vec_t vt [11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    int drops;
    int we_seen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;

    // Five reads with pushes, then five drains in push order.
    vt[0]  = mk(1, 1, 'h100, 'h001, 'h000, 1, 0, 'd0,   'h000, 0, 0, 'h000);
    vt[1]  = mk(1, 1, 'h101, 'h002, 'hABC, 1, 0, 'd1,   'h000, 1, 0, 'h000);
    vt[2]  = mk(1, 1, 'h102, 'h003, 'h123, 1, 0, 'd2,   'h000, 2, 1, 'hABC);
    vt[3]  = mk(1, 1, 'h103, 'h004, 'h7E1, 1, 0, 'd3,   'h000, 3, 1, 'h123);
    vt[4]  = mk(1, 1, 'h104, 'h005, 'h456, 1, 0, 'd4,   'h000, 4, 1, 'h7E1);
    vt[5]  = mk(0, 0, 'h000, 'h000, 'hFFF, 1, 1, 'h100, 'h001, 5, 1, 'h456);
    vt[6]  = mk(0, 0, 'h000, 'h000, 'hBAD, 1, 1, 'h101, 'h002, 4, 1, 'hFFF);
    vt[7]  = mk(0, 0, 'h000, 'h000, 'hBAD, 1, 1, 'h102, 'h003, 3, 0, 'hFFF);
    vt[8]  = mk(0, 0, 'h000, 'h000, 'hBAD, 1, 1, 'h103, 'h004, 2, 0, 'hFFF);
    vt[9]  = mk(0, 0, 'h000, 'h000, 'hBAD, 1, 1, 'h104, 'h005, 1, 0, 'hFFF);
    vt[10] = mk(0, 0, 'h000, 'h000, 'hBAD, 0, 0, 'h000, 'h000, 0, 0, 'hFFF);

    reset = 1; rez_160x120 = 0; rez_320x240 = 1;
    activeArea = 1; Vsync = 1; wr_req = 1; wr_addr = 'h1; wr_data = 'h1; mem_rdata = '0;
    next_cycle();
    @(negedge CLK25);
    check("rst_mem_en",   32'(mem_en),     0);
    check("rst_level",    32'(fifo_level), 0);
    check("rst_pix_valid",32'(pix_valid),  0);
    check("rst_drop_cnt", 32'(drop_cnt),   0);
    next_cycle();
    reset = 0; activeArea = 0; wr_req = 0;
    @(negedge CLK25);
    check("rst_idle_en",  32'(mem_en),     0);
    check("rst_wr_drop",  32'(wr_drop),    0);
    check("rst_pix_data", 32'(pix_data),   0);
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      activeArea = vt[i].act; wr_req = vt[i].wr; wr_addr = vt[i].wa;
      wr_data = vt[i].wd; mem_rdata = vt[i].rd;
      @(negedge CLK25);
      check($sformatf("v%0d_en", i),    32'(mem_en),     32'(vt[i].en));
      check($sformatf("v%0d_we", i),    32'(mem_we),     32'(vt[i].we));
      check($sformatf("v%0d_addr", i),  32'(mem_addr),   32'(vt[i].addr));
      check($sformatf("v%0d_wdata", i), 32'(mem_wdata),  32'(vt[i].wdata));
      check($sformatf("v%0d_level", i), 32'(fifo_level), 32'(vt[i].lvl));
      check($sformatf("v%0d_pv", i),    32'(pix_valid),  32'(vt[i].pv));
      check($sformatf("v%0d_pix", i),   32'(pix_data),   32'(vt[i].pix));
      check($sformatf("v%0d_drop", i),  32'(wr_drop),    0);
      next_cycle();
    end

    // Overflow: 20 pushes while reads own the RAM.
    drops = 0; we_seen = 0;
    for (int i = 0; i < 22; i++) begin
      activeArea = 1;
      wr_req  = (i < 20);
      wr_addr = AW'(200 + i);
      wr_data = DW'(i);
      @(negedge CLK25);
      if (mem_we)  we_seen++;
      if (wr_drop) drops++;
      next_cycle();
    end
    wr_req = 0;
    check("ovf_drop_pulses", 32'(drops),      4);
    check("ovf_no_write",    32'(we_seen),    0);
    check("ovf_drop_cnt",    32'(drop_cnt),   4);
    check("ovf_level",       32'(fifo_level), 16);

    // Full FIFO with a write slot: push and pop together.
    activeArea = 0; wr_req = 1; wr_addr = 'd300; wr_data = 'h300;
    @(negedge CLK25);
    check("full_pp_we",   32'(mem_we),   1);
    check("full_pp_addr", 32'(mem_addr), 200);
    next_cycle();
    wr_req = 0;
    @(negedge CLK25);
    check("full_pp_level", 32'(fifo_level), 16);
    check("full_pp_drop",  32'(wr_drop),    0);
    errs = 0;
    for (int j = 1; j <= 16; j++) begin
      exp_a = (j < 16) ? AW'(200 + j) : AW'(300);
      exp_d = (j < 16) ? DW'(j) : DW'('h300);
      if (j > 1) @(negedge CLK25);
      if (!(mem_en && mem_we && mem_addr == exp_a && mem_wdata == exp_d)) errs++;
      next_cycle();
    end
    @(negedge CLK25);
    check("drain_order",  32'(errs),       0);
    check("drain_level",  32'(fifo_level), 0);
    check("drain_idle",   32'(mem_en),     0);
    next_cycle();

    // Saturation: 16 accepted then 252 more drops takes the count past 255.
    for (int i = 0; i < 270; i++) begin
      activeArea = 1;
      wr_req = (i < 268);
      wr_addr = AW'(i);
      wr_data = DW'(i);
      next_cycle();
    end
    wr_req = 0;
    @(negedge CLK25);
    check("sat_drop_cnt", 32'(drop_cnt),   255);
    check("sat_level",    32'(fifo_level), 16);
    next_cycle();

    // Frame start in blanking, then 20000 reads: no wrap at 19199 under 320x240,
    // even after rez_160x120 rises mid-frame.
    activeArea = 0; Vsync = 0; mem_rdata = 'h5A5;
    next_cycle();
    Vsync = 1;
    errs = 0;
    for (int i = 0; i < 20000; i++) begin
      activeArea = 1;
      if (i == 100) rez_160x120 = 1;
      @(negedge CLK25);
      if (!(mem_en && !mem_we && mem_addr == AW'(i))) errs++;
      next_cycle();
    end
    check("addr_seq_320", 32'(errs), 0);

    // Frame start coinciding with a read: this read keeps its address, next is 0.
    Vsync = 0;
    @(negedge CLK25);
    check("fs_read_addr", 32'(mem_addr), 20000);
    next_cycle();
    Vsync = 1;
    errs = 0;
    exp_a = '0;
    for (int i = 0; i < 19205; i++) begin
      @(negedge CLK25);
      if (!(mem_en && !mem_we && mem_addr == exp_a)) errs++;
      exp_a = (exp_a == AW'(19199)) ? '0 : exp_a + AW'(1);
      next_cycle();
    end
    check("addr_seq_160_wrap", 32'(errs), 0);
    check("pre_rst_pv",        32'(pix_valid), 1);

    // Reset in the middle of the frame.
    reset = 1;
    @(negedge CLK25);
    check("midrst_mem_en", 32'(mem_en), 0);
    next_cycle();
    reset = 0; activeArea = 0;
    @(negedge CLK25);
    check("midrst_level",     32'(fifo_level), 0);
    check("midrst_drop_cnt",  32'(drop_cnt),   0);
    check("midrst_pix_valid", 32'(pix_valid),  0);
    check("midrst_pix_data",  32'(pix_data),   0);
    check("midrst_en_idle",   32'(mem_en),     0);
    next_cycle();
    activeArea = 1;
    @(negedge CLK25);
    check("midrst_addr0", 32'(mem_addr), 0);
    next_cycle();
    activeArea = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
- Schedules a single-port synchronous frame-buffer RAM between two users: camera pixel writes and VGA pixel reads.
- VGA reads have absolute priority inside the active area.
- Camera writes are buffered in an internal FIFO and drained during blanking.
- Generates the linear read address from the VGA timing block's activeArea/Vsync and returns registered pixels to the DAC path.

Parameters:
- AW, 19, frame-buffer address width (covers 640x480 = 307200 words).
- DW, 12, pixel width (RGB444).
- FIFO_DEPTH, 16, write FIFO depth in entries; power of two.
- CW, 8, width of the saturating dropped-write counter.

Ports:
- CLK25  input  1  pixel clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high.
- rez_160x120  input  1  resolution select; has priority over rez_320x240.
- rez_320x240  input  1  resolution select; 640x480 when both selects are 0.
- activeArea  input  1  from the VGA timing block; high means a pixel is fetched this cycle.
- Vsync  input  1  from the VGA timing block, active-low.
- wr_req  input  1  camera write request, single-cycle, already synchronous to CLK25.
- wr_addr  input  AW  camera write address.
- wr_data  input  DW  camera write data.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  AW  RAM address.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM read data, valid one cycle after a read enable.
- pix_data  output  DW  pixel to the VGA output.
- pix_valid  output  1  pix_data is valid.
- wr_drop  output  1  one-cycle pulse when a camera write is discarded.
- drop_cnt  output  CW  saturating count of dropped writes.
- fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; read address 0.
  - frame_size is loaded from the rez inputs: 19200, 76800 or 307200.
  - The Vsync edge detector is primed to 1.
- Frame start:
  - Defined as a Vsync falling edge (registered Vsync = 1, current Vsync = 0).
  - Read address is cleared to 0.
  - frame_size is reloaded from the rez inputs.
  - Rez changes therefore take effect only at the next frame start.
- Read slot (activeArea = 1):
  - mem_en = 1, mem_we = 0, mem_addr = read address.
  - Read address increments after each read.
  - If the read address equals frame_size-1 when a read issues, it wraps to 0.
- Write slot (activeArea = 0 and FIFO non-empty):
  - Pop the FIFO head.
  - mem_en = 1, mem_we = 1, mem_addr/mem_wdata = head entry.
  - One write per cycle.
- Idle (activeArea = 0 and FIFO empty): mem_en = 0.
- Memory outputs are combinational from state and activeArea. A read is never delayed.
- Pixel return:
  - Pipeline: mem_rdata is registered into pix_data.
  - pix_valid is activeArea delayed by exactly 2 cycles.
  - Latency from the activeArea cycle to pix_valid is 2.
  - pix_data holds its value while pix_valid = 0.
- FIFO push (wr_req = 1):
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle (full + simultaneous push/pop leaves the level unchanged).
  - Otherwise the write is dropped: wr_drop pulses for 1 cycle; drop_cnt increments and saturates at 2^CW-1.
- Simultaneous frame start and read: frame start wins; the address is 0 for the following read.
- Reset mid-operation:
  - FIFO contents are discarded and drop_cnt is cleared.
  - Any in-flight pixel is discarded (pix_valid = 0 the next cycle).
- fifo_level is registered. Level 0 = empty; level FIFO_DEPTH = full.

Test Plan:
- Reset with rez_320x240 = 1, then run one frame of activeArea (320 cycles high per line × 240 lines) -> mem_addr 0..76799 in order, then wraps to 0 at the next Vsync falling edge; pix_valid rises 2 cycles after the first activeArea.
- Preload mem_rdata = 12'hABC on the cycle after a read -> pix_data = 12'hABC with pix_valid = 1 exactly 2 cycles after the activeArea cycle.
- Issue 5 wr_req during activeArea = 1 -> no mem_we while activeArea = 1; fifo_level = 5. Then drop activeArea -> 5 consecutive mem_we cycles with addresses/data in push order; fifo_level returns to 0.
- Issue 20 wr_req with activeArea held at 1 -> first 16 accepted; 4 wr_drop pulses; drop_cnt = 4; fifo_level = 16.
- FIFO full, activeArea = 0, wr_req = 1 -> push and pop in the same cycle; fifo_level stays 16; no wr_drop.
- Change rez_160x120 to 1 mid-frame -> address sequence is unchanged until the next Vsync falling edge, after which it wraps at 19199; assert reset mid-frame -> outputs 0, FIFO empty, drop_cnt = 0 on the next cycle.
